// File: rtl/phase_sched_pkg.sv
// Shared types and constants for the junction phase scheduler.
// Optional pre-emption is built only when PHASE_SCHED_PREEMPT_EN is defined.
package phase_sched_pkg;

    localparam int N_LANES = 32;
    localparam int SEL_W   = 5;

    localparam int GREEN_CYC_DEF  = 16;
    localparam int YELLOW_CYC_DEF = 4;
    localparam int CLEAR_CYC_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        CLEAR  = 2'd3
    } phase_t;

    // Largest of three interval lengths; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        else       m = m;
        if (c > m) m = c;
        else       m = m;
        return m;
    endfunction

endpackage

// File: rtl/rr_pick32.sv
// Combinational 32-way rotating priority picker.
// Lane ptr+1 has highest priority, ptr itself the lowest.
module rr_pick32
    import phase_sched_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand_s;
    logic             hit_s;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        any    = 1'b0;
        idx    = {SEL_W{1'b0}};
        cand_s = {SEL_W{1'b0}};
        hit_s  = 1'b0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            cand_s = ptr + SEL_W'(k + 1);   // wraps modulo 32
            hit_s  = req[cand_s];
            any    = any | hit_s;
            idx    = hit_s ? cand_s : idx;
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Round-robin phase controller for the 32-lane junction.
// Each grant runs GREEN, YELLOW and all-red CLEAR for fixed cycle counts.
// Defining PHASE_SCHED_PREEMPT_EN adds the preempt / preempt_lane ports.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int GREEN_CYC  = GREEN_CYC_DEF,
    parameter int YELLOW_CYC = YELLOW_CYC_DEF,
    parameter int CLEAR_CYC  = CLEAR_CYC_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [N_LANES-1:0] req,
`ifdef PHASE_SCHED_PREEMPT_EN
    input  logic               preempt,
    input  logic [SEL_W-1:0]   preempt_lane,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [N_LANES-1:0] grant,
    output logic [1:0]         phase,
    output logic               busy
);

    localparam int TW = $clog2(max3(GREEN_CYC, YELLOW_CYC, CLEAR_CYC) + 1);
    localparam logic [TW-1:0]      G_LOAD   = TW'(GREEN_CYC - 1);
    localparam logic [TW-1:0]      Y_LOAD   = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0]      C_LOAD   = TW'(CLEAR_CYC - 1);
    localparam logic [TW-1:0]      T_ZERO   = TW'(0);
    localparam logic [TW-1:0]      T_ONE    = TW'(1);
    localparam logic [N_LANES-1:0] ONE_HOT0 = {{(N_LANES-1){1'b0}}, 1'b1};

    phase_t             phase_r, phase_n_s;
    logic [TW-1:0]      timer_r, timer_n_s;
    logic [SEL_W-1:0]   sel_r, sel_n_s;
    logic [SEL_W-1:0]   ptr_r, ptr_n_s;
    logic [N_LANES-1:0] grant_r, grant_n_s;
    logic               busy_r;

    logic               pick_any_s;
    logic [SEL_W-1:0]   pick_idx_s;
    logic               go_s;
    logic [SEL_W-1:0]   go_lane_s;
    logic               go_rr_s;
    logic               start_s;
    logic               timer_zero_s;

`ifdef PHASE_SCHED_PREEMPT_EN
    logic               pend_r, pend_n_s;
    logic [SEL_W-1:0]   pend_lane_r, pend_lane_n_s;
    logic               pre_hit_s;
    logic [SEL_W-1:0]   pre_lane_s;
`endif

    rr_pick32 u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    assign timer_zero_s = (timer_r == T_ZERO);

    // Who would be granted if this cycle were a decision point.
    always_comb begin
`ifdef PHASE_SCHED_PREEMPT_EN
        if (preempt) begin
            pre_hit_s  = 1'b1;
            pre_lane_s = preempt_lane;
        end else begin
            pre_hit_s  = pend_r;
            pre_lane_s = pend_lane_r;
        end
        if (pre_hit_s) begin
            go_s      = 1'b1;
            go_lane_s = pre_lane_s;
            go_rr_s   = 1'b0;      // pre-emptive grants leave ptr alone
        end else begin
            go_s      = enable & pick_any_s;
            go_lane_s = pick_idx_s;
            go_rr_s   = 1'b1;
        end
`else
        go_s      = enable & pick_any_s;
        go_lane_s = pick_idx_s;
        go_rr_s   = 1'b1;
`endif
    end

    // Phase sequencing, interval timer and next output values.
    always_comb begin
        phase_n_s = phase_r;
        timer_n_s = timer_r;
        sel_n_s   = sel_r;
        ptr_n_s   = ptr_r;
        grant_n_s = grant_r;
        start_s   = 1'b0;
`ifdef PHASE_SCHED_PREEMPT_EN
        pend_n_s      = pend_r;
        pend_lane_n_s = pend_lane_r;
        if ((phase_r != IDLE) && preempt &&
            !((phase_r == GREEN) && (sel_r == preempt_lane))) begin
            pend_n_s      = 1'b1;
            pend_lane_n_s = preempt_lane;
        end else begin
            pend_n_s      = pend_n_s;
        end
`endif
        case (phase_r)
            IDLE: begin
                if (go_s) start_s = 1'b1;
                else      start_s = 1'b0;
            end
            GREEN: begin
`ifdef PHASE_SCHED_PREEMPT_EN
                if (preempt && (sel_r != preempt_lane)) begin
                    phase_n_s = YELLOW;
                    timer_n_s = Y_LOAD;
                end else if (preempt) begin
                    timer_n_s = G_LOAD;    // hold GREEN on the pre-empting lane
                end else
`endif
                if (timer_zero_s) begin
                    phase_n_s = YELLOW;
                    timer_n_s = Y_LOAD;
                end else begin
                    timer_n_s = timer_r - T_ONE;
                end
            end
            YELLOW: begin
                if (timer_zero_s) begin
                    phase_n_s = CLEAR;
                    timer_n_s = C_LOAD;
                    grant_n_s = {N_LANES{1'b0}};
                end else begin
                    timer_n_s = timer_r - T_ONE;
                end
            end
            CLEAR: begin
                if (timer_zero_s) begin
                    if (go_s) begin
                        start_s = 1'b1;
                    end else begin
                        phase_n_s = IDLE;
                        timer_n_s = T_ZERO;
                    end
                end else begin
                    timer_n_s = timer_r - T_ONE;
                end
            end
            default: begin
                phase_n_s = IDLE;
                timer_n_s = T_ZERO;
                grant_n_s = {N_LANES{1'b0}};
            end
        endcase
        if (start_s) begin
            phase_n_s = GREEN;
            timer_n_s = G_LOAD;
            sel_n_s   = go_lane_s;
            grant_n_s = ONE_HOT0 << go_lane_s;
            if (go_rr_s) ptr_n_s = go_lane_s;
            else         ptr_n_s = ptr_r;
`ifdef PHASE_SCHED_PREEMPT_EN
            pend_n_s = 1'b0;
`endif
        end else begin
            sel_n_s = sel_n_s;
        end
    end

    // State and output registers; asynchronous reset to the idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= IDLE;
            timer_r <= T_ZERO;
            sel_r   <= {SEL_W{1'b0}};
            ptr_r   <= {SEL_W{1'b1}};    // lane 0 searched first
            grant_r <= {N_LANES{1'b0}};
            busy_r  <= 1'b0;
`ifdef PHASE_SCHED_PREEMPT_EN
            pend_r      <= 1'b0;
            pend_lane_r <= {SEL_W{1'b0}};
`endif
        end else begin
            phase_r <= phase_n_s;
            timer_r <= timer_n_s;
            sel_r   <= sel_n_s;
            ptr_r   <= ptr_n_s;
            grant_r <= grant_n_s;
            busy_r  <= (phase_n_s != IDLE);
`ifdef PHASE_SCHED_PREEMPT_EN
            pend_r      <= pend_n_s;
            pend_lane_r <= pend_lane_n_s;
`endif
        end
    end

    assign phase = phase_r;
    assign sel   = sel_r;
    assign grant = grant_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler (default build, no pre-emption).
module tb_phase_scheduler;

    localparam int G = 16;
    localparam int Y = 4;
    localparam int C = 2;
    localparam int T = G + Y + C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] req = 32'd0;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic [1:0]  phase;
    logic        busy;

    always #5 clk = ~clk;

    phase_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .req    (req),
        .sel    (sel),
        .grant  (grant),
        .phase  (phase),
        .busy   (busy)
    );

    // Reference model: a grant is described by its age in cycles since GREEN began.
    bit m_idle;
    int m_age;
    int m_sel;
    int m_ptr;

    int n_cmp = 0;
    int n_err = 0;
    int prev_phase = 0;
    int order_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_age  = 0;
        m_sel  = 0;
        m_ptr  = 31;
    endtask

    task automatic model_edge(input logic [31:0] r, input logic en);
        if (m_idle || m_age == T - 1) begin
            if (en && r != 32'd0) begin
                for (int j = 1; j <= 32; j++) begin
                    int lane;
                    lane = (m_ptr + j) % 32;
                    if (r[lane]) begin
                        m_sel = lane;
                        break;
                    end
                end
                m_ptr  = m_sel;
                m_age  = 0;
                m_idle = 1'b0;
            end else begin
                m_idle = 1'b1;
                m_age  = 0;
            end
        end else begin
            m_age++;
        end
    endtask

    function automatic int exp_phase();
        if (m_idle)             return 0;
        else if (m_age < G)     return 1;
        else if (m_age < G + Y) return 2;
        else                    return 3;
    endfunction

    task automatic check_all(input string where);
        int ep;
        logic [31:0] eg;
        ep = exp_phase();
        eg = (ep == 1 || ep == 2) ? (32'd1 << m_sel) : 32'd0;
        chk({where, "/phase"}, {30'd0, phase}, 32'(ep));
        chk({where, "/sel"},   {27'd0, sel},   32'(m_sel));
        chk({where, "/grant"}, grant,          eg);
        chk({where, "/busy"},  {31'd0, busy},  {31'd0, !m_idle});
    endtask

    task automatic step(input string where);
        logic [31:0] r;
        logic        en;
        r  = req;
        en = enable;
        @(posedge clk);
        model_edge(r, en);
        #1;
        check_all(where);
        if (phase == 2'd1 && prev_phase != 1) order_q.push_back(int'(sel));
        prev_phase = int'(phase);
    endtask

    task automatic do_reset(input string where);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(where);
        prev_phase = 0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int exp_order[4];
        int hold;
        exp_order = '{0, 4, 31, 0};

        // Power-on reset.
        #1 rst = 1'b1;
        model_reset();
        #1 check_all("reset");
        #1 rst = 1'b0;

        // Single lane 0 grant, full sequence, then idle.
        req = 32'h0000_0001; enable = 1'b1;
        step("single");
        req = 32'h0;
        repeat (T + 2) step("single");
        chk("single_idle", {30'd0, phase}, 32'd0);

        // Three requesters held: order 0, 4, 31, 0 with no idle bubble.
        do_reset("rst2");
        order_q.delete();
        req = 32'h8000_0011;
        repeat (4 * T) step("rr3");
        chk("rr3_count", order_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("rr3_order", (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);

        // Lone requester lane 7 is re-granted.
        order_q.delete();
        req = 32'h0000_0080;
        repeat (4 * T) step("lone7");
        chk("lone7_last", (order_q.size() > 0) ? order_q[$] : -1, 32'd7);

        // enable dropped during GREEN of lane 2.
        do_reset("rst4");
        req = 32'h0000_0004; enable = 1'b1;
        repeat (5) step("endrop");
        enable = 1'b0;
        repeat (T + 5) step("endrop");
        chk("endrop_busy", {31'd0, busy}, 32'd0);
        chk("endrop_sel", {27'd0, sel}, 32'd2);

        // Reset in YELLOW, then all lanes requesting.
        enable = 1'b1; req = 32'h0000_0100;
        repeat (G + 2) step("yel");
        chk("yel_phase", {30'd0, phase}, 32'd2);
        do_reset("rst_yel");
        chk("rst_yel_grant", grant, 32'd0);
        req = 32'hFFFF_FFFF;
        step("all");
        chk("all_sel0", {27'd0, sel}, 32'd0);
        repeat (T) step("all");

        // Randomized traffic against the model.
        for (int s = 0; s < 45; s++) begin
            case ($urandom % 4)
                0:       req = 32'd0;
                1:       req = 32'd1 << ($urandom % 32);
                2:       req = $urandom & $urandom & $urandom;
                default: req = $urandom;
            endcase
            enable = (($urandom % 5) != 0);
            if (($urandom % 15) == 0) do_reset("rnd_rst");
            hold = $urandom_range(1, 30);
            repeat (hold) step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
